// File: rtl/ddfs_pkg.sv
// Shared widths, DAC command and state/sample types for the FIR-to-DAC transmit path.
package ddfs_pkg;

    localparam int unsigned FIR_OUT_W      = 32;
    localparam int unsigned DAC_W          = 16;
    localparam int unsigned FIR_FRAC_SHIFT = 15;

    localparam logic [7:0] DAC_CMD_WRITE = 8'h30;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } dac_tx_state_t;

    typedef logic signed [15:0] dac_sample_t;

endpackage

// File: rtl/fir_quantizer.sv
// Combinational round-half-up and saturate of a Q-scaled FIR result down to OUT_W bits.
module fir_quantizer
    import ddfs_pkg::*;
#(
    parameter int unsigned IN_W       = FIR_OUT_W,
    parameter int unsigned OUT_W      = DAC_W,
    parameter int unsigned FRAC_SHIFT = FIR_FRAC_SHIFT
) (
    input  logic signed [IN_W-1:0]  i_data,
    output logic        [OUT_W-1:0] o_q,
    output logic                    o_sat
);

    localparam logic signed [IN_W:0] RND  = (IN_W+1)'(2 ** (FRAC_SHIFT - 1));
    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W:0] MINV = ~MAXV;

    logic signed [IN_W:0] w_sum;
    logic signed [IN_W:0] w_shr;

    // One guard bit keeps the rounding add from wrapping near full scale.
    assign w_sum = $signed({i_data[IN_W-1], i_data}) + RND;
    assign w_shr = w_sum >>> FRAC_SHIFT;

    always_comb begin
        o_q   = w_shr[OUT_W-1:0];
        o_sat = 1'b0;
        if (w_shr > MAXV) begin
            o_q   = MAXV[OUT_W-1:0];
            o_sat = 1'b1;
        end else if (w_shr < MINV) begin
            o_q   = MINV[OUT_W-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/fir_dac_tx.sv
// FIR sample to SPI mode-0 DAC frame transmitter ({CMD, quantized sample}, MSB first).
// Optional DAC_OFFSET_BIN_EN: send offset-binary (sample MSB inverted) instead of two's complement.
module fir_dac_tx
    import ddfs_pkg::*;
#(
    parameter int unsigned IN_W       = FIR_OUT_W,
    parameter int unsigned OUT_W      = DAC_W,
    parameter int unsigned FRAC_SHIFT = FIR_FRAC_SHIFT,
    parameter logic [7:0]  CMD        = DAC_CMD_WRITE,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned CS_GAP     = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IN_W-1:0] s_data_i,
    input  logic            s_valid_i,
    output logic            s_ready_o,
    output logic            dac_sclk_o,
    output logic            dac_mosi_o,
    output logic            dac_cs_n_o,
    output logic            busy_o,
    output logic            sat_o
);

    localparam int unsigned FRAME_W = 8 + OUT_W;
    localparam int unsigned BIT_W   = $clog2(FRAME_W);
    localparam int unsigned DIV_W   = $clog2(CLK_DIV) + 1;
    localparam int unsigned GAP_W   = $clog2(CS_GAP) + 1;

    dac_tx_state_t        r_state, w_state_nxt;
    logic [FRAME_W-1:0]   r_shift, w_shift_nxt;
    logic [DIV_W-1:0]     r_div, w_div_nxt;
    logic                 r_phase, w_phase_nxt;
    logic [BIT_W-1:0]     r_bit, w_bit_nxt;
    logic [GAP_W-1:0]     r_gap, w_gap_nxt;
    logic                 r_sclk, w_sclk_nxt;
    logic                 r_mosi, w_mosi_nxt;
    logic                 r_cs_n, w_cs_n_nxt;
    logic                 r_sat, w_sat_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_busy, w_busy_nxt;

    logic [OUT_W-1:0]     w_q;
    logic [OUT_W-1:0]     w_word;
    logic                 w_sat;
    logic                 w_accept;

    fir_quantizer #(
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_quant (
        .i_data (s_data_i),
        .o_q    (w_q),
        .o_sat  (w_sat)
    );

`ifdef DAC_OFFSET_BIN_EN
    assign w_word = {~w_q[OUT_W-1], w_q[OUT_W-2:0]};
`else
    assign w_word = w_q;
`endif

    assign w_accept = s_valid_i && r_ready;

    // Quantization happens on the accept edge so LOAD-cycle outputs come straight from flops.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_div_nxt   = r_div;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        w_gap_nxt   = r_gap;
        w_sclk_nxt  = r_sclk;
        w_mosi_nxt  = r_mosi;
        w_cs_n_nxt  = r_cs_n;
        w_sat_nxt   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = LOAD;
                    w_shift_nxt = {CMD, w_word};
                    w_mosi_nxt  = CMD[7];
                    w_cs_n_nxt  = 1'b0;
                    w_sat_nxt   = w_sat;
                end
            end
            LOAD: begin
                w_state_nxt = SHIFT;
                w_div_nxt   = '0;
                w_phase_nxt = 1'b0;
                w_bit_nxt   = '0;
            end
            SHIFT: begin
                if (r_div == DIV_W'(CLK_DIV - 1)) begin
                    w_div_nxt = '0;
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                        w_sclk_nxt  = 1'b1;
                    end else if (r_bit == BIT_W'(FRAME_W - 1)) begin
                        w_state_nxt = GAP;
                        w_sclk_nxt  = 1'b0;
                        w_mosi_nxt  = 1'b0;
                        w_cs_n_nxt  = 1'b1;
                        w_gap_nxt   = '0;
                    end else begin
                        // Falling SCLK is the only point where MOSI advances.
                        w_bit_nxt   = r_bit + BIT_W'(1);
                        w_phase_nxt = 1'b0;
                        w_sclk_nxt  = 1'b0;
                        w_shift_nxt = r_shift << 1;
                        w_mosi_nxt  = r_shift[FRAME_W-2];
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            GAP: begin
                if (r_gap == GAP_W'(CS_GAP - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_nxt = r_gap + GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cs_n_nxt  = 1'b1;
                w_sclk_nxt  = 1'b0;
                w_mosi_nxt  = 1'b0;
            end
        endcase

        w_ready_nxt = (w_state_nxt == IDLE);
        w_busy_nxt  = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_div   <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_sat   <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_div   <= w_div_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
            r_gap   <= w_gap_nxt;
            r_sclk  <= w_sclk_nxt;
            r_mosi  <= w_mosi_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_sat   <= w_sat_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign s_ready_o  = r_ready;
    assign dac_sclk_o = r_sclk;
    assign dac_mosi_o = r_mosi;
    assign dac_cs_n_o = r_cs_n;
    assign busy_o     = r_busy;
    assign sat_o      = r_sat;

endmodule

// File: tb/tb_fir_dac_tx.sv
// Randomized and directed bench for fir_dac_tx against a cycle-indexed frame model.
module tb_fir_dac_tx;

    localparam int CD     = 2;
    localparam int CSG    = 4;
    localparam int PERIOD = 2 + 48 * CD + CSG;
`ifdef DAC_OFFSET_BIN_EN
    localparam logic [15:0] OFFS = 16'h8000;
`else
    localparam logic [15:0] OFFS = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_data_i;
    logic        s_valid_i;
    logic        s_ready_o, dac_sclk_o, dac_mosi_o, dac_cs_n_o, busy_o, sat_o;

    fir_dac_tx dut (
        .clk        (clk),
        .reset      (reset),
        .s_data_i   (s_data_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .dac_sclk_o (dac_sclk_o),
        .dac_mosi_o (dac_mosi_o),
        .dac_cs_n_o (dac_cs_n_o),
        .busy_o     (busy_o),
        .sat_o      (sat_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          t_since = -1;
    logic [23:0] cur_frame = '0;
    logic        cur_sat = 1'b0;
    logic [23:0] cap = '0;
    int          ncap = 0;
    int          cs_low = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_cs = 1'b1;
    int          frames_done = 0;
    logic [23:0] last_frame = '0;
    logic        dut_sat_load = 1'b0;
    int          accept_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // Returns {sat, dac_word}: round half up, arithmetic shift, clamp to 16-bit signed.
    function automatic logic [16:0] model_q(input logic [31:0] d);
        longint s;
        longint q;
        logic   sat;
        logic [15:0] w;
        s   = longint'($signed(d));
        q   = (s + 64'sd16384) >>> 15;
        sat = 1'b0;
        if (q > 64'sd32767) begin
            q = 64'sd32767;
            sat = 1'b1;
        end else if (q < -64'sd32768) begin
            q = -64'sd32768;
            sat = 1'b1;
        end
        w = q[15:0] ^ OFFS;
        return {sat, w};
    endfunction

    // Per-cycle comparison against the frame timeline measured from the accept cycle.
    always @(negedge clk) begin
        logic e_ready, e_busy, e_cs, e_sclk, e_mosi, e_sat;
        logic [16:0] m;
        int k;
        cyc++;
        if (reset) begin
            t_since   = -1;
            ncap      = 0;
            cap       = '0;
            cs_low    = 0;
            prev_sclk = 1'b0;
            prev_cs   = 1'b1;
        end else if (t_since >= 0) begin
            t_since++;
            if (t_since == PERIOD) t_since = -1;
        end

        e_ready = 1'b1; e_busy = 1'b0; e_cs = 1'b1;
        e_sclk  = 1'b0; e_mosi = 1'b0; e_sat = 1'b0;
        if (t_since == 1) begin
            e_ready = 1'b0; e_busy = 1'b1; e_cs = 1'b0;
            e_mosi  = cur_frame[23]; e_sat = cur_sat;
            dut_sat_load = sat_o;
        end else if (t_since >= 2 && t_since < 2 + 48 * CD) begin
            k = t_since - 2;
            e_ready = 1'b0; e_busy = 1'b1; e_cs = 1'b0;
            e_sclk  = ((k / CD) % 2) == 1;
            e_mosi  = cur_frame[23 - k / (2 * CD)];
        end else if (t_since >= 2 + 48 * CD) begin
            e_ready = 1'b0; e_busy = 1'b1;
        end

        chk("ready", 32'(s_ready_o), 32'(e_ready));
        chk("busy",  32'(busy_o),    32'(e_busy));
        chk("cs_n",  32'(dac_cs_n_o), 32'(e_cs));
        chk("sclk",  32'(dac_sclk_o), 32'(e_sclk));
        chk("mosi",  32'(dac_mosi_o), 32'(e_mosi));
        chk("sat",   32'(sat_o),     32'(e_sat));

        if (!reset) begin
            if (dac_sclk_o && !prev_sclk && !dac_cs_n_o) begin
                cap = {cap[22:0], dac_mosi_o};
                ncap++;
            end
            if (!dac_cs_n_o) cs_low++;
            if (dac_cs_n_o && !prev_cs) begin
                chk("frame_bits", 32'(ncap), 32'd24);
                chk("frame_data", 32'(cap), 32'(cur_frame));
                chk("cs_low_len", 32'(cs_low), 32'(1 + 48 * CD));
                last_frame = cap;
                frames_done++;
                ncap = 0; cap = '0; cs_low = 0;
            end
            prev_sclk = dac_sclk_o;
            prev_cs   = dac_cs_n_o;
            if (s_valid_i && e_ready) begin
                m = model_q(s_data_i);
                cur_sat   = m[16];
                cur_frame = {8'h30, m[15:0]};
                t_since   = 0;
                accept_q.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        logic got;
        bit   ok;
        ok = 1'b0;
        s_data_i  = d;
        s_valid_i = 1'b1;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            got = s_ready_o;
            step();
            if (got) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        s_valid_i = 1'b0;
        s_data_i  = $urandom;
    endtask

    task automatic wait_frame();
        int f0;
        bit ok;
        f0 = frames_done;
        ok = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            step();
            if (frames_done != f0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic directed(input string name, input logic [31:0] d,
                            input logic [15:0] lit, input logic lit_sat);
        send(d);
        wait_frame();
        chk(name, 32'(last_frame), 32'({8'h30, lit ^ OFFS}));
        chk({name, "_sat"}, 32'(dut_sat_load), 32'(lit_sat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int sel;
        reset     = 1'b1;
        s_valid_i = 1'b0;
        s_data_i  = '0;

        chk("model_8000", 32'(model_q(32'h0000_8000)), 32'({1'b0, 16'h0001 ^ OFFS}));
        chk("model_bfff", 32'(model_q(32'hFFFF_BFFF)), 32'({1'b0, 16'hFFFF ^ OFFS}));
        chk("model_sat_n", 32'(model_q(32'h8000_0000)), 32'({1'b1, 16'h8000 ^ OFFS}));

        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();

        reset = 1'b1;
        #2;
        chk("rst_idle_cs", 32'(dac_cs_n_o), 32'd1);
        chk("rst_idle_rdy", 32'(s_ready_o), 32'd1);
        step();
        reset = 1'b0;
        step();

        directed("t2_frame",  32'h0000_8000, 16'h0001, 1'b0);
        directed("rnd_3fff",  32'h0000_3FFF, 16'h0000, 1'b0);
        directed("rnd_4000",  32'h0000_4000, 16'h0001, 1'b0);
        directed("rnd_c000",  32'hFFFF_C000, 16'h0000, 1'b0);
        directed("rnd_bfff",  32'hFFFF_BFFF, 16'hFFFF, 1'b0);
        directed("rnd_7fff",  32'h7FFF_FFFF, 16'h7FFF, 1'b1);
        directed("sat_pos",   32'h4000_0000, 16'h7FFF, 1'b1);
        directed("sat_neg",   32'h8000_0000, 16'h8000, 1'b1);

        // Back-to-back with data changing every cycle.
        accept_q.delete();
        s_valid_i = 1'b1;
        v = int'($urandom);
        for (int i = 0; i < 4 * PERIOD + 5; i++) begin
            s_data_i = 32'(v + i * 4099);
            step();
        end
        s_valid_i = 1'b0;
        wait_frame();
        repeat (PERIOD) step();
        chk("b2b_count", 32'(accept_q.size() >= 4), 32'd1);
        for (int i = 1; i < accept_q.size(); i++)
            chk("b2b_spacing", 32'(accept_q[i] - accept_q[i-1]), 32'(PERIOD));

        // Reset after the 10th SCLK rise drops the frame immediately.
        send($urandom);
        for (int i = 0; i < 3 * PERIOD && ncap < 10; i++) step();
        chk("mid_rst_reached", 32'(ncap >= 10), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_cs", 32'(dac_cs_n_o), 32'd1);
        chk("mid_rst_sclk", 32'(dac_sclk_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        directed("post_rst", 32'h0000_8000, 16'h0001, 1'b0);

        // Random traffic with random valid gaps.
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: v = int'($urandom);
                1: v = int'($urandom_range(0, 131071)) - 65536;
                2: v = (int'($urandom_range(0, 20)) - 10) * 32768 + 16383 + int'($urandom_range(0, 1));
                default: v = ($urandom_range(0, 1) == 1 ? 1 : -1) * 32767 * 32768
                             + int'($urandom_range(0, 65535)) - 32768;
            endcase
            s_data_i  = 32'(v);
            s_valid_i = ($urandom_range(0, 3) == 0);
            step();
        end
        s_valid_i = 1'b0;
        repeat (PERIOD + 5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_dac_tx.md
Name: fir_dac_tx

Overview:
Transmit back-end for the FIR output path: accepts one 32-bit filtered sample per frame and quantizes the Q15-scaled FIR result to 16 bits with round-half-up and saturation. Serializes the command plus sample as a 24-bit SPI-mode-0 frame to an external DAC. Sits between the FIR and the board DAC pins; the valid/ready handshake back-pressures the sample source.

Parameters:
IN_W, 32, input sample width (FIR accumulator width)
OUT_W, 16, DAC data width
FRAC_SHIFT, 15, right shift applied to input (FIR taps sum ≈ 2^15)
CMD, 8'h30, 8-bit DAC command prefixed to every frame
CLK_DIV, 2, clk cycles per SCLK half-period (≥1)
CS_GAP, 4, clk cycles cs_n held high between frames (≥1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
s_data_i  in  IN_W  signed FIR sample
s_valid_i  in  1  sample valid
s_ready_o  out  1  block can accept a sample
dac_sclk_o  out  1  SPI clock, idles low
dac_mosi_o  out  1  SPI data, MSB first
dac_cs_n_o  out  1  DAC chip select, active low
busy_o  out  1  frame in progress (state != IDLE)
sat_o  out  1  one-cycle pulse: current sample was clipped

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-high. During/after reset: state IDLE, s_ready_o=1, dac_cs_n_o=1, dac_sclk_o=0, dac_mosi_o=0, busy_o=0, sat_o=0, bit counter=0, divider=0.
- FSM: IDLE -> LOAD -> SHIFT -> GAP -> IDLE.
- IDLE: s_ready_o=1. On s_valid_i&&s_ready_o, register s_data_i and go to LOAD. s_ready_o is 0 in every other state.
- LOAD (1 cycle):
  - Quantize: sum = s_data + 2^(FRAC_SHIFT-1), computed at IN_W+1 bits so no wrap. q = sum >>> FRAC_SHIFT (arithmetic).
  - Clamp q to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Pulse sat_o=1 this cycle if clamped.
  - Load shift reg {CMD, q[OUT_W-1:0]}. dac_cs_n_o=0, dac_mosi_o=frame MSB.
- SHIFT: 24 bits.
  - Per bit: CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
  - mosi changes only when sclk falls or on LOAD entry, so it is stable for the whole rising edge.
  - After the 24th high phase: sclk=0, mosi=0, cs_n=1, go to GAP.
- GAP: CS_GAP cycles, then IDLE.
- Frame period from accept to next ready: 1 + 1 + 48*CLK_DIV + CS_GAP cycles (102 at defaults).
- Back-to-back: with s_valid_i held high, the next sample is accepted on the first IDLE cycle. s_data_i changes while busy are ignored.
- Async reset mid-frame: cs_n deasserts immediately; the partial frame is dropped and no sample is retained.
- sat_o is never asserted outside LOAD.

Optional Feature:
DAC_OFFSET_BIN_EN
- Defined: invert q[OUT_W-1] after clamp, giving offset-binary for unipolar DACs. 0x0001 -> 0x8001; 0x8000 -> 0x0000.
- Undefined: two's complement is sent unchanged.
- sat_o behaviour is identical either way.

Decomposition:
- Package ddfs_pkg:
  - FIR_OUT_W=32, DAC_W=16, FIR_FRAC_SHIFT=15.
  - DAC_CMD_WRITE=8'h30.
  - typedef enum dac_tx_state_t {IDLE, LOAD, SHIFT, GAP}.
  - typedef logic signed [15:0] dac_sample_t.
- Sub-module fir_quantizer: combinational round+saturate, outputs q and sat flag; parameterized by IN_W/OUT_W/FRAC_SHIFT. Reusable for other FIR taps-out paths.

Test Plan:
1. Assert reset mid-idle and after power-up -> cs_n=1, sclk=0, mosi=0, s_ready_o=1, sat_o=0, busy_o=0.
2. s_data_i=32'h0000_8000, valid one cycle -> sampled serial frame 24'h30_0001 MSB first. Exactly 24 sclk rising edges, cs_n low for 97 cycles, ready again 102 cycles after accept, sat_o never high.
3. Rounding sweep:
   - 32'h0000_3FFF->0x0000
   - 32'h0000_4000->0x0001
   - 32'hFFFF_C000->0x0000
   - 32'hFFFF_BFFF->0xFFFF
   - 32'h7FFF_FFFF->0x7FFF (no wrap, sat_o=1)
4. Saturation: 32'h4000_0000->0x7FFF with sat_o one-cycle pulse in LOAD; 32'h8000_0000->0x8000 with sat_o pulse.
5. s_valid_i held high, data incrementing every cycle -> only the values present on accept cycles are sent, accepts exactly 102 cycles apart, s_ready_o low throughout busy.
6. Reset asserted after 10th sclk rise -> cs_n=1 and sclk=0 within the same cycle. The next sample sends a complete 24-bit frame. With DAC_OFFSET_BIN_EN, test 2 frame becomes 24'h30_8001.
